// File: rtl/plic_pkg.sv
// Shared types and default sizes for the PLIC interrupt scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package plic_pkg;

   localparam int PLIC_SRC_NUM_DEF    = 32;
   localparam int PLIC_PRIO_WIDTH_DEF = 3;
   localparam int PLIC_ID_WIDTH_DEF   = $clog2(PLIC_SRC_NUM_DEF);

   // Gateway life cycle: waiting for a request, pending arbitration, claimed by the target
   typedef enum logic [1:0] {
      GW_IDLE = 2'd0,
      GW_PEND = 2'd1,
      GW_BUSY = 2'd2
   } plic_gw_state_e;

   typedef logic [PLIC_ID_WIDTH_DEF-1:0]   plic_id_t;
   typedef logic [PLIC_PRIO_WIDTH_DEF-1:0] plic_prio_t;

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: IDLE/PEND/BUSY, optional rising-edge capture (PLIC_SCHED_EDGE_EN).
// Latency: pend_o rises one cycle after the request is sampled; claim/complete act at the next edge.
// Backpressure: none; an edge arriving while PEND/BUSY is held in a one-deep missed flag, more are dropped.
module plic_gateway
   import plic_pkg::*;
(
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic req_i,
`ifdef PLIC_SCHED_EDGE_EN
   input  logic edge_i,
`endif
   input  logic claim_i,
   input  logic complete_i,
   output logic pend_o,
   output logic busy_o
);

   plic_gw_state_e state;
   logic           trig;
   logic           edge_seen;

`ifdef PLIC_SCHED_EDGE_EN
   logic prev;
   logic missed;
   logic rise;

   assign rise      = req_i & ~prev;
   assign edge_seen = edge_i & rise;
   assign trig      = edge_i ? rise : req_i;

   // Previous-value flop for edge detection and the one-deep missed-edge flag
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         prev   <= 1'b0;
         missed <= 1'b0;
      end else begin
         prev <= req_i;
         if (state == GW_BUSY && complete_i) begin
            missed <= 1'b0;
         end else if (state != GW_IDLE && edge_seen) begin
            missed <= 1'b1;
         end
      end
   end
`else
   logic missed;

   assign trig      = req_i;
   assign edge_seen = 1'b0;
   assign missed    = 1'b0;
`endif

   // Gateway FSM with registered pending/busy outputs
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state  <= GW_IDLE;
         pend_o <= 1'b0;
         busy_o <= 1'b0;
      end else begin
         case (state)
            GW_IDLE: begin
               if (trig) begin
                  state  <= GW_PEND;
                  pend_o <= 1'b1;
               end
            end
            GW_PEND: begin
               if (claim_i) begin
                  state  <= GW_BUSY;
                  pend_o <= 1'b0;
                  busy_o <= 1'b1;
               end
            end
            GW_BUSY: begin
               if (complete_i) begin
                  busy_o <= 1'b0;
                  // A captured edge (earlier or this very cycle) goes straight back to pending
                  if (missed || edge_seen) begin
                     state  <= GW_PEND;
                     pend_o <= 1'b1;
                  end else begin
                     state <= GW_IDLE;
                  end
               end
            end
            default: begin
               state  <= GW_IDLE;
               pend_o <= 1'b0;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/apb4_plic_sched.sv
// PLIC scheduler for one target: per-source gateways plus max-priority/lowest-ID arbitration.
// Latency: pend one cycle after request; claim_id_o/irq_o combinational from registered state.
// Backpressure: none; claim with no winner is a no-op, complete of a non-busy ID is ignored. Edge mode via PLIC_SCHED_EDGE_EN.
module apb4_plic_sched
   import plic_pkg::*;
#(
   parameter int SRC_NUM    = PLIC_SRC_NUM_DEF,
   parameter int PRIO_WIDTH = PLIC_PRIO_WIDTH_DEF,
   localparam int ID_WIDTH  = $clog2(SRC_NUM)
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic [SRC_NUM-1:0]            irq_src_i,
   input  logic [SRC_NUM*PRIO_WIDTH-1:0] prio_i,
   input  logic [SRC_NUM-1:0]            en_i,
   input  logic [PRIO_WIDTH-1:0]         thold_i,
`ifdef PLIC_SCHED_EDGE_EN
   input  logic [SRC_NUM-1:0]            edge_i,
`endif
   input  logic                          claim_i,
   input  logic                          complete_i,
   input  logic [ID_WIDTH-1:0]           complete_id_i,
   output logic [ID_WIDTH-1:0]           claim_id_o,
   output logic                          irq_o,
   output logic [SRC_NUM-1:0]            pend_o,
   output logic [SRC_NUM-1:0]            busy_o
);

   logic [PRIO_WIDTH-1:0] best_prio;
   logic                  unused_bits;

   // ID 0 means "no interrupt" and never pends
   assign pend_o[0] = 1'b0;
   assign busy_o[0] = 1'b0;

`ifdef PLIC_SCHED_EDGE_EN
   assign unused_bits = ^{irq_src_i[0], en_i[0], prio_i[PRIO_WIDTH-1:0], edge_i[0]};
`else
   assign unused_bits = ^{irq_src_i[0], en_i[0], prio_i[PRIO_WIDTH-1:0]};
`endif

   for (genvar k = 1; k < SRC_NUM; k++) begin : g_gw
      plic_gateway u_gw (
         .clk_i      (clk_i),
         .rst_n_i    (rst_n_i),
         .req_i      (irq_src_i[k]),
`ifdef PLIC_SCHED_EDGE_EN
         .edge_i     (edge_i[k]),
`endif
         .claim_i    (claim_i && (claim_id_o == ID_WIDTH'(k))),
         .complete_i (complete_i && (complete_id_i == ID_WIDTH'(k))),
         .pend_o     (pend_o[k]),
         .busy_o     (busy_o[k])
      );
   end

   // Winner search: strictly greater than the running best, so ties keep the lower ID
   // and starting from the threshold enforces prio > thold
   always_comb begin
      best_prio  = thold_i;
      claim_id_o = '0;
      for (int k = 1; k < SRC_NUM; k++) begin
         if (pend_o[k] && en_i[k] && (prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > best_prio)) begin
            best_prio  = prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
            claim_id_o = ID_WIDTH'(k);
         end
      end
   end

   assign irq_o = (claim_id_o != '0);

endmodule

// File: tb/tb_apb4_plic_sched.sv
module tb_apb4_plic_sched;

   localparam int N  = 32;
   localparam int PW = 3;
   localparam int IW = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    irq;
   logic [N*PW-1:0] prio;
   logic [N-1:0]    en;
   logic [PW-1:0]   thold;
   logic [N-1:0]    edge_v;
   logic            claim;
   logic            complete;
   logic [IW-1:0]   cid;
   logic [IW-1:0]   claim_id;
   logic            irq_out;
   logic [N-1:0]    pend;
   logic [N-1:0]    busy;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [IW-1:0] id;
      logic          irq;
      logic [N-1:0]  pend;
      logic [N-1:0]  busy;
   } exp_t;

   exp_t exp_q[$];

   // reference model: sets of pending/busy sources plus edge bookkeeping
   bit [N-1:0] m_pend, m_busy, m_missed, m_prev;

   always #5 clk = ~clk;

   apb4_plic_sched dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .irq_src_i     (irq),
      .prio_i        (prio),
      .en_i          (en),
      .thold_i       (thold),
`ifdef PLIC_SCHED_EDGE_EN
      .edge_i        (edge_v),
`endif
      .claim_i       (claim),
      .complete_i    (complete),
      .complete_id_i (cid),
      .claim_id_o    (claim_id),
      .irq_o         (irq_out),
      .pend_o        (pend),
      .busy_o        (busy)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // highest priority level first, then lowest ID within that level
   function automatic int model_win();
      for (int p = (1 << PW) - 1; p > int'(thold); p--)
         for (int k = 1; k < N; k++)
            if (m_pend[k] && en[k] && int'(prio[k*PW +: PW]) == p) return k;
      return 0;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_busy = '0; m_missed = '0; m_prev = '0;
   endtask

   // state change at a clock edge, from the inputs applied during the cycle
   task automatic model_step();
      int w;
      bit rise;
      bit [N-1:0] np, nb, nm;
      if (!rst_n) begin
         model_reset();
         return;
      end
      w = model_win();
      np = m_pend; nb = m_busy; nm = m_missed;
      for (int k = 1; k < N; k++) begin
         rise = irq[k] && !m_prev[k];
         if (m_busy[k]) begin
            if (complete && int'(cid) == k) begin
               nb[k] = 0;
               if (m_missed[k] || (edge_v[k] && rise)) np[k] = 1;
               nm[k] = 0;
            end else if (edge_v[k] && rise) nm[k] = 1;
         end else if (m_pend[k]) begin
            if (claim && w == k) begin np[k] = 0; nb[k] = 1; end
            if (edge_v[k] && rise) nm[k] = 1;
         end else begin
            if (edge_v[k] ? rise : irq[k]) np[k] = 1;
         end
      end
      m_pend = np; m_busy = nb; m_missed = nm; m_prev = irq;
   endtask

   // push the expectation for the current inputs, then advance one clock
   task automatic step();
      exp_t e;
      e.id   = IW'(model_win());
      e.irq  = (e.id != 0);
      e.pend = m_pend;
      e.busy = m_busy;
      exp_q.push_back(e);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // monitor: compare DUT outputs against queued expectations away from the active edge
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("sb_claim_id", 64'(claim_id), 64'(e.id));
         chk("sb_irq",      64'(irq_out),  64'(e.irq));
         chk("sb_pend",     64'(pend),     64'(e.pend));
         chk("sb_busy",     64'(busy),     64'(e.busy));
      end
   end

   initial begin
      rst_n = 1'b0; irq = '1; prio = '0; en = '1; thold = '0;
      edge_v = '0; claim = 0; complete = 0; cid = '0;
      model_reset();
      @(posedge clk); #1;

      // reset with all sources high
      step();
      chk("rst_pend", 64'(pend), 64'(0));
      chk("rst_irq",  64'(irq_out), 64'(0));
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_pend", 64'(pend), 64'(32'hFFFF_FFFE));
      irq = '0;
      do_reset();

      // tie on priority goes to the lower ID; claim moves to the next winner
      prio[3*PW +: PW] = 3'd5; prio[7*PW +: PW] = 3'd5; thold = 3'd4;
      irq[3] = 1; irq[7] = 1; step(); irq = '0;
      #1 chk("tie_id", 64'(claim_id), 64'(3));
      claim = 1; step();
      chk("after_claim_id", 64'(claim_id), 64'(7));
      chk("busy3", 64'(busy[3]), 64'(1));
      step(); claim = 0;
      complete = 1; cid = 5'd3; step(); cid = 5'd7; step(); complete = 0;
      prio = '0;

      // threshold is a strict compare and takes effect combinationally
      prio[5*PW +: PW] = 3'd2; thold = 3'd2; irq[5] = 1; step(); irq = '0;
      #1 chk("thold_eq_irq", 64'(irq_out), 64'(0));
      thold = 3'd1;
      #1 chk("thold_lower_id", 64'(claim_id), 64'(5));
      step(); claim = 1; step(); claim = 0;
      complete = 1; cid = 5'd5; step(); complete = 0; prio = '0; thold = '0;

      // level source re-pends one cycle after completion
      prio[9*PW +: PW] = 3'd1; irq[9] = 1; step();
      claim = 1; step(); claim = 0;
      complete = 1; cid = 5'd9; step(); complete = 0;
      chk("lvl_idle_pend", 64'(pend[9]), 64'(0));
      chk("lvl_idle_busy", 64'(busy[9]), 64'(0));
      step();
      chk("lvl_repend", 64'(pend[9]), 64'(1));
      complete = 1; cid = 5'd4; step(); complete = 0;
      chk("idle_complete", 64'(pend), 64'(32'h200));
      irq[9] = 0; claim = 1; step(); claim = 0;
      complete = 1; cid = 5'd9; step(); complete = 0; step();
      chk("lvl_drained", 64'(pend), 64'(0));
      prio = '0;

      // claim with no winner; simultaneous claim and complete
      claim = 1; step(); claim = 0;
      chk("empty_claim", 64'({pend, busy}), 64'(0));
      prio[2*PW +: PW] = 3'd2; prio[6*PW +: PW] = 3'd2;
      irq[6] = 1; step(); irq = '0; claim = 1; step(); claim = 0;
      irq[2] = 1; step(); irq = '0;
      claim = 1; complete = 1; cid = 5'd6; step(); claim = 0; complete = 0;
      chk("simul_busy2", 64'(busy[2]), 64'(1));
      chk("simul_busy6", 64'(busy[6]), 64'(0));
      complete = 1; cid = 5'd2; step(); complete = 0; prio = '0;

`ifdef PLIC_SCHED_EDGE_EN
      // edge source: many pulses while busy give one re-pend; steady high gives none
      edge_v[8] = 1; prio[8*PW +: PW] = 3'd3;
      irq[8] = 1; step(); irq[8] = 0; step();
      claim = 1; step(); claim = 0;
      for (int i = 0; i < 3; i++) begin
         irq[8] = 1; step(); irq[8] = 0; step();
      end
      complete = 1; cid = 5'd8; step(); complete = 0;
      chk("edge_repend", 64'(pend[8]), 64'(1));
      claim = 1; step(); claim = 0;
      complete = 1; cid = 5'd8; step(); complete = 0; step();
      chk("edge_once", 64'(pend[8]), 64'(0));
      irq[8] = 1; step(); claim = 1; step(); claim = 0;
      complete = 1; cid = 5'd8; step(); complete = 0;
      step(); step(); step();
      chk("edge_steady", 64'(pend[8]), 64'(0));
      irq[8] = 0; edge_v = '0; prio = '0; step();
`endif

      // randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         if (c % 60 == 0) begin
            prio  = {$urandom, $urandom, $urandom};
            en    = $urandom | $urandom;
            thold = PW'($urandom_range(0, 3));
`ifdef PLIC_SCHED_EDGE_EN
            edge_v = $urandom;
`endif
         end
         irq   = $urandom & $urandom & $urandom;
         claim = ($urandom_range(0, 2) == 0);
         complete = ($urandom_range(0, 1) == 0);
         cid = IW'($urandom_range(0, N - 1));
         for (int t = 0; t < 8 && !m_busy[cid]; t++) cid = IW'($urandom_range(0, N - 1));
         step();
      end
      claim = 0; complete = 0; irq = '0;

      @(negedge clk); #1;
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
